// File: rtl/apb_uart_responder.sv
// apb_uart_responder
//   Zero-wait-state APB completer standing in for a UART in the simulation top.
//   A TX FIFO is drained at a fixed pace onto io_uart_out_valid/io_uart_out_ch.
//   The host injects characters into an RX FIFO through rx_in_valid/rx_in_ch.
//   uart_irq is a level interrupt.
// Ports
//   clock, reset             : clock; asynchronous active-low reset
//   uart_p*                  : APB completer (paddr[3:2] decoded, pstrb[0] honoured)
//   uart_prdata              : read data, registered at setup, held through access
//   uart_irq                 : (rx_irq_en & rx_nonempty) | (txempty_irq_en & tx_empty)
//   io_uart_out_valid/_ch    : one-cycle pulse per character leaving the TX FIFO
//   rx_in_valid/rx_in_ch     : host-side RX character push
// Register map (paddr[3:2])
//   0 TXDATA (W)  1 RXDATA (R, pops)  2 STATUS (R)  3 CTRL (RW, bit4 write clears sticky bits)
module apb_uart_responder #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int TX_DIV   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] uart_paddr,
  input  logic        uart_psel,
  input  logic        uart_penable,
  input  logic        uart_pwrite,
  input  logic [31:0] uart_pwdata,
  input  logic [3:0]  uart_pstrb,
  output logic [31:0] uart_prdata,
  output logic        uart_irq,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  input  logic        rx_in_valid,
  input  logic [7:0]  rx_in_ch
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int PCW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [PCW-1:0] PACE_LAST   = PCW'(TX_DIV - 1);
  localparam logic [TAW:0]   TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]   RX_FULL_CNT = (RAW+1)'(RX_DEPTH);

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [7:0]     tx_mem_d [TX_DEPTH];
  logic [TAW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [TAW:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [7:0]     rx_mem_d [RX_DEPTH];
  logic [RAW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [RAW:0]   rx_cnt_q, rx_cnt_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic           tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
  logic [PCW-1:0] pace_q, pace_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_ch_q, out_ch_d;
  logic [31:0]    prdata_q, prdata_d;

  logic        setup, access;
  logic [1:0]  addr;
  logic        tx_full, tx_empty, rx_full, rx_nonempty;
  logic        tx_wr, tx_push, tx_pop, rx_push, rx_pop;
  logic        ctrl_wr, sticky_clr;
  logic [31:0] status, rd_mux;
  logic        unused_bits;

  assign unused_bits = ^{uart_paddr[63:4], uart_paddr[1:0], uart_pstrb[3:1], uart_pwdata[31:8]};

  assign setup       = uart_psel & ~uart_penable;
  assign access      = uart_psel & uart_penable;
  assign addr        = uart_paddr[3:2];
  assign tx_full     = (tx_cnt_q == TX_FULL_CNT);
  assign tx_empty    = (tx_cnt_q == '0);
  assign rx_full     = (rx_cnt_q == RX_FULL_CNT);
  assign rx_nonempty = (rx_cnt_q != '0);

  assign tx_wr      = access & uart_pwrite & (addr == 2'd0) & uart_pstrb[0];
  assign tx_push    = tx_wr & ~tx_full;
  assign tx_pop     = ~tx_empty & (pace_q == PACE_LAST);
  assign rx_push    = rx_in_valid & ~rx_full;
  // Pop only if the value latched at setup actually carried a character.
  assign rx_pop     = access & ~uart_pwrite & (addr == 2'd1) & prdata_q[31];
  assign ctrl_wr    = access & uart_pwrite & (addr == 2'd3) & uart_pstrb[0];
  assign sticky_clr = ctrl_wr & uart_pwdata[4];

  assign status = {26'b0, tx_ovf_q, rx_ovr_q, rx_full, tx_empty, tx_full, rx_nonempty};

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd1:    rd_mux = rx_nonempty ? {1'b1, 23'b0, rx_mem_q[rx_rd_q]} : 32'h0;
      2'd2:    rd_mux = status;
      2'd3:    rd_mux = {30'b0, ctrl_q};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = uart_pwdata[7:0];
      tx_wr_d           = tx_wr_q + TAW'(1);
    end
    if (tx_pop) tx_rd_d = tx_rd_q + TAW'(1);
    tx_cnt_d = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);

    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = rx_in_ch;
      rx_wr_d           = rx_wr_q + RAW'(1);
    end
    if (rx_pop) rx_rd_d = rx_rd_q + RAW'(1);
    rx_cnt_d = rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
  end

  always_comb begin
    // Pacing only runs while there is something to send.
    pace_d = '0;
    if (!tx_empty && pace_q != PACE_LAST) pace_d = pace_q + PCW'(1);
    out_valid_d = tx_pop;
    out_ch_d    = tx_pop ? tx_mem_q[tx_rd_q] : 8'h0;

    ctrl_d = ctrl_wr ? uart_pwdata[1:0] : ctrl_q;
    // Set has priority over a same-cycle clear.
    tx_ovf_d = (tx_wr & tx_full) | (tx_ovf_q & ~sticky_clr);
    rx_ovr_d = (rx_in_valid & rx_full) | (rx_ovr_q & ~sticky_clr);

    prdata_d = '0;
    if (setup)       prdata_d = rd_mux;
    else if (access) prdata_d = prdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
      tx_rd_q     <= '0;
      tx_wr_q     <= '0;
      tx_cnt_q    <= '0;
      rx_rd_q     <= '0;
      rx_wr_q     <= '0;
      rx_cnt_q    <= '0;
      ctrl_q      <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      pace_q      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      prdata_q    <= '0;
    end else begin
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_rd_q     <= tx_rd_d;
      tx_wr_q     <= tx_wr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_rd_q     <= rx_rd_d;
      rx_wr_q     <= rx_wr_d;
      rx_cnt_q    <= rx_cnt_d;
      ctrl_q      <= ctrl_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_ovr_q    <= rx_ovr_d;
      pace_q      <= pace_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      prdata_q    <= prdata_d;
    end
  end

  assign uart_prdata       = prdata_q;
  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;
  assign uart_irq          = (ctrl_q[0] & rx_nonempty) | (ctrl_q[1] & tx_empty);

endmodule

// File: tb/tb_apb_uart_responder.sv
module tb_apb_uart_responder;

  localparam int TXD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        rx_in_valid = 1'b0;
  logic [7:0]  rx_in_ch = '0;

  logic [31:0] prdata_f, prdata_s;
  logic        irq_f, irq_s, ov_f, ov_s;
  logic [7:0]  ch_f, ch_s;

  int checks = 0;
  int passed = 0;
  int pcyc = 0;
  int slow_pulses = 0;
  int log_t[$];
  logic [7:0] log_ch[$];

  always #5 clock = ~clock;

  apb_uart_responder #(.TX_DEPTH(16), .RX_DEPTH(16), .TX_DIV(TXD)) dut (
    .clock(clock), .reset(reset), .uart_paddr(paddr), .uart_psel(psel),
    .uart_penable(penable), .uart_pwrite(pwrite), .uart_pwdata(pwdata),
    .uart_pstrb(pstrb), .uart_prdata(prdata_f), .uart_irq(irq_f),
    .io_uart_out_valid(ov_f), .io_uart_out_ch(ch_f),
    .rx_in_valid(rx_in_valid), .rx_in_ch(rx_in_ch));

  apb_uart_responder #(.TX_DEPTH(16), .RX_DEPTH(16), .TX_DIV(1000)) dut_slow (
    .clock(clock), .reset(reset), .uart_paddr(paddr), .uart_psel(psel),
    .uart_penable(penable), .uart_pwrite(pwrite), .uart_pwdata(pwdata),
    .uart_pstrb(pstrb), .uart_prdata(prdata_s), .uart_irq(irq_s),
    .io_uart_out_valid(ov_s), .io_uart_out_ch(ch_s),
    .rx_in_valid(rx_in_valid), .rx_in_ch(rx_in_ch));

  always @(posedge clock) pcyc <= pcyc + 1;

  always @(negedge clock) begin
    if (ov_f) begin
      log_t.push_back(pcyc);
      log_ch.push_back(ch_f);
    end
    if (ov_s) slow_pulses++;
  end

  // All tasks start and end on a negedge; transfers are back-to-back capable.
  task automatic apb_xfer(input logic wr, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd_f, output logic [31:0] rd_s);
    paddr      = {$urandom(), $urandom()};
    paddr[3:2] = a;
    psel = 1'b1; penable = 1'b0; pwrite = wr; pwdata = d; pstrb = s;
    @(negedge clock);
    penable = 1'b1;
    @(negedge clock);
    rd_f = prdata_f;
    rd_s = prdata_s;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] df, ds;
    apb_xfer(1'b1, a, d, 4'hF, df, ds);
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [31:0] rf, output logic [31:0] rs);
    apb_xfer(1'b0, a, $urandom(), 4'h0, rf, rs);
  endtask

  task automatic rx_drive(input logic [7:0] c);
    rx_in_valid = 1'b1;
    rx_in_ch    = c;
    @(negedge clock);
    rx_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_in_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    log_t.delete();
    log_ch.delete();
    slow_pulses = 0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [31:0] rf, rs;
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if ({prdata_f, irq_f, ov_f, ch_f} !== 42'h0) $display("FAIL reset_outputs_in_reset: got %h want 0", {prdata_f, irq_f, ov_f, ch_f});
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({prdata_f, irq_f, ov_f, ch_f} !== 42'h0) $display("FAIL reset_outputs_after: got %h want 0", {prdata_f, irq_f, ov_f, ch_f});
    else passed++;
    apb_read(2'd2, rf, rs);
    checks++;
    if (rf !== 32'h4) $display("FAIL reset_status: got %h want 00000004", rf);
    else passed++;
    checks++;
    if (rs !== 32'h4) $display("FAIL reset_status_slow: got %h want 00000004", rs);
    else passed++;
    apb_read(2'd3, rf, rs);
    checks++;
    if (rf !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", rf);
    else passed++;
    apb_read(2'd1, rf, rs);
    checks++;
    if (rf !== 32'h0) $display("FAIL reset_rxdata: got %h want 0", rf);
    else passed++;
    @(negedge clock);
    checks++;
    if (prdata_f !== 32'h0) $display("FAIL prdata_idle: got %h want 0", prdata_f);
    else passed++;
  endtask

  task automatic test_tx_pace();
    logic [31:0] rf, rs;
    int t0, n;
    do_reset();
    apb_write(2'd0, 32'h41);
    t0 = pcyc;
    apb_write(2'd0, 32'h42);
    n = 0;
    while (log_ch.size() < 2 && n < 40) begin @(negedge clock); n++; end
    checks++;
    if (log_ch.size() != 2) $display("FAIL tx_pulse_count: got %0d want 2", log_ch.size());
    else begin
      passed++;
      checks++;
      if (log_ch[0] !== 8'h41) $display("FAIL tx_ch0: got %h want 41", log_ch[0]);
      else passed++;
      checks++;
      if (log_ch[1] !== 8'h42) $display("FAIL tx_ch1: got %h want 42", log_ch[1]);
      else passed++;
      checks++;
      if (log_t[0] - t0 != TXD) $display("FAIL tx_first_latency: got %0d want %0d", log_t[0] - t0, TXD);
      else passed++;
      checks++;
      if (log_t[1] - log_t[0] != TXD) $display("FAIL tx_spacing: got %0d want %0d", log_t[1] - log_t[0], TXD);
      else passed++;
    end
    apb_read(2'd2, rf, rs);
    checks++;
    if (rf !== 32'h4) $display("FAIL tx_status_after: got %h want 00000004", rf);
    else passed++;
    // Strobe bit 0 low: the write must not push anything.
    apb_xfer(1'b1, 2'd0, 32'h99, 4'hE, rf, rs);
    repeat (3 * TXD) @(negedge clock);
    checks++;
    if (log_ch.size() != 2) $display("FAIL tx_strobe_ignored: got %0d pulses want 2", log_ch.size());
    else passed++;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rf, rs;
    do_reset();
    for (int i = 0; i < 17; i++) apb_write(2'd0, 32'h60 + i);
    apb_read(2'd2, rf, rs);
    checks++;
    if (rs !== 32'h22) $display("FAIL tx_overflow_status: got %h want 00000022", rs);
    else passed++;
    checks++;
    if (slow_pulses != 0) $display("FAIL tx_overflow_no_emit: got %0d pulses want 0", slow_pulses);
    else passed++;
    apb_write(2'd3, 32'h10);
    apb_read(2'd2, rf, rs);
    checks++;
    if (rs !== 32'h02) $display("FAIL tx_overflow_clear: got %h want 00000002", rs);
    else passed++;
    apb_read(2'd3, rf, rs);
    checks++;
    if (rs !== 32'h0) $display("FAIL ctrl_clear_not_stored: got %h want 0", rs);
    else passed++;
  endtask

  task automatic test_rx_irq();
    logic [31:0] rf, rs;
    do_reset();
    apb_write(2'd3, 32'h1);
    checks++;
    if (irq_f !== 1'b0) $display("FAIL irq_idle: got %b want 0", irq_f);
    else passed++;
    rx_drive(8'h55);
    checks++;
    if (irq_f !== 1'b1) $display("FAIL irq_rx_set: got %b want 1", irq_f);
    else passed++;
    apb_read(2'd1, rf, rs);
    checks++;
    if (rf !== 32'h8000_0055) $display("FAIL rx_read1: got %h want 80000055", rf);
    else passed++;
    checks++;
    if (irq_f !== 1'b0) $display("FAIL irq_rx_drop: got %b want 0", irq_f);
    else passed++;
    apb_read(2'd1, rf, rs);
    checks++;
    if (rf !== 32'h0) $display("FAIL rx_read2: got %h want 0", rf);
    else passed++;
    apb_write(2'd3, 32'h2);
    checks++;
    if (irq_f !== 1'b1) $display("FAIL irq_txempty: got %b want 1", irq_f);
    else passed++;
    apb_read(2'd3, rf, rs);
    checks++;
    if (rf !== 32'h2) $display("FAIL ctrl_readback: got %h want 2", rf);
    else passed++;
    apb_write(2'd0, 32'h7A);
    checks++;
    if (irq_f !== 1'b0) $display("FAIL irq_tx_nonempty: got %b want 0", irq_f);
    else passed++;
  endtask

  task automatic test_rx_full();
    logic [31:0] rf, rs;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      rx_in_valid = 1'b1;
      rx_in_ch    = 8'(i);
      @(negedge clock);
    end
    rx_in_valid = 1'b0;
    apb_read(2'd2, rf, rs);
    // rx_nonempty | tx_empty | rx_full | rx_overrun
    checks++;
    if (rf !== 32'h1D) $display("FAIL rx_full_status: got %h want 0000001d", rf);
    else passed++;
    for (int i = 1; i <= 16; i++) begin
      apb_read(2'd1, rf, rs);
      checks++;
      if (rf !== (32'h8000_0000 | 32'(i))) $display("FAIL rx_order_%0d: got %h want %h", i, rf, 32'h8000_0000 | 32'(i));
      else passed++;
    end
    apb_read(2'd2, rf, rs);
    checks++;
    if (rf !== 32'h14) $display("FAIL rx_drained_status: got %h want 00000014", rf);
    else passed++;
    apb_write(2'd3, 32'h10);
    apb_read(2'd2, rf, rs);
    checks++;
    if (rf !== 32'h4) $display("FAIL rx_overrun_clear: got %h want 00000004", rf);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rf, rs;
    int n, sz;
    do_reset();
    apb_write(2'd0, 32'h31);
    apb_write(2'd0, 32'h32);
    apb_write(2'd0, 32'h33);
    n = 0;
    while (log_ch.size() == 0 && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (log_ch.size() == 0) $display("FAIL reset_mid_first_pulse: got none want 1");
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if ({ov_f, ch_f} !== 9'h0) $display("FAIL reset_mid_async: got %h want 0", {ov_f, ch_f});
    else passed++;
    sz = log_ch.size();
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    checks++;
    if (log_ch.size() != sz) $display("FAIL reset_mid_no_more: got %0d pulses want %0d", log_ch.size(), sz);
    else passed++;
    apb_read(2'd2, rf, rs);
    checks++;
    if (rf !== 32'h4) $display("FAIL reset_mid_status: got %h want 00000004", rf);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0]  rxm[$];
    logic [7:0]  txm[$];
    logic        ovr, c0;
    logic [31:0] rf, rs, exp, d;
    logic [7:0]  ch;
    logic [3:0]  s;
    int          op, n;
    ovr = 1'b0;
    c0  = 1'b0;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: if (txm.size() - log_ch.size() < 12) begin
             ch = 8'($urandom());
             s  = 4'($urandom_range(0, 15));
             apb_xfer(1'b1, 2'd0, {24'($urandom()), ch}, s, rf, rs);
             if (s[0]) txm.push_back(ch);
           end
        1, 5: begin
             ch = 8'($urandom());
             rx_drive(ch);
             if (rxm.size() == 16) ovr = 1'b1;
             else rxm.push_back(ch);
           end
        2: begin
             apb_read(2'd1, rf, rs);
             exp = (rxm.size() != 0) ? {1'b1, 23'b0, rxm[0]} : 32'h0;
             if (rxm.size() != 0) void'(rxm.pop_front());
             checks++;
             if (rf !== exp) $display("FAIL rand_rxdata_%0d: got %h want %h", i, rf, exp);
             else passed++;
           end
        3: begin
             apb_read(2'd2, rf, rs);
             exp = {26'b0, 1'b0, ovr, rxm.size() == 16, 2'b00, rxm.size() != 0};
             checks++;
             if ((rf & ~32'h6) !== exp) $display("FAIL rand_status_%0d: got %h want %h (tx bits masked)", i, rf & ~32'h6, exp);
             else passed++;
           end
        default: begin
             d    = $urandom();
             d[1] = 1'b0;
             apb_write(2'd3, d);
             c0 = d[0];
             if (d[4]) ovr = 1'b0;
             apb_read(2'd3, rf, rs);
             checks++;
             if (rf !== {31'b0, c0}) $display("FAIL rand_ctrl_%0d: got %h want %h", i, rf, {31'b0, c0});
             else passed++;
           end
      endcase
      checks++;
      if (irq_f !== (c0 && rxm.size() != 0)) $display("FAIL rand_irq_%0d: got %b want %b", i, irq_f, c0 && rxm.size() != 0);
      else passed++;
    end
    n = 0;
    while (log_ch.size() < txm.size() && n < 400) begin @(negedge clock); n++; end
    repeat (2 * TXD) @(negedge clock);
    checks++;
    if (log_ch.size() != txm.size()) $display("FAIL rand_tx_count: got %0d want %0d", log_ch.size(), txm.size());
    else begin
      passed++;
      for (int k = 0; k < txm.size(); k++) begin
        checks++;
        if (log_ch[k] !== txm[k]) $display("FAIL rand_tx_ch_%0d: got %h want %h", k, log_ch[k], txm[k]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_pace();
    test_tx_overflow();
    test_rx_irq();
    test_rx_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
